// File: rtl/seq_controller_pkg.sv
// Shared definitions for the Y86 sequential-datapath stage sequencer.
// Covers status codes, instruction codes and the sequencer state encoding.
package seq_pkg;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WB,
    S_PCUPD,
    S_HALTED,
    S_FAULT
  } state_t;

  // Instructions that touch data memory and therefore wait on mem_ready.
  function automatic logic is_mem_op(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IMRMOVQ) || (icode == ICALL) ||
           (icode == IRET)    || (icode == IPUSHQ)  || (icode == IPOPQ);
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Control/status bundle between the stage sequencer and its datapath/bench.
// The slave side is the sequencer; the master side drives run/step and memory status.
interface seq_controller_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic             clear;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             mem_ready;
  logic             dmem_error;
  logic             en_fetch;
  logic             en_decode;
  logic             en_execute;
  logic             en_memory;
  logic             en_wb;
  logic             en_pc;
  logic             mem_req;
  logic [1:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] cycles;

  modport slave (
    input  run, step, clear, icode, instr_valid, imem_error, mem_ready, dmem_error,
    output en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc,
    output mem_req, stat, busy, retired, cycles
  );

  modport master (
    output run, step, clear, icode, instr_valid, imem_error, mem_ready, dmem_error,
    input  en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc,
    input  mem_req, stat, busy, retired, cycles
  );

endinterface

// File: rtl/seq_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle Y86 stage sequencer: one-hot stage strobes, memory wait/timeout,
// sticky status, run/step control and retired/cycle counters.
module seq_controller
  import seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int MAX_INSTR   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_controller_if.slave bus
);

  localparam int               TO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(MEM_TIMEOUT - 1);
  localparam logic             LIMIT_ON = (MAX_INSTR > 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_INSTR);
  localparam logic [CNT_W-1:0] LIMIT_M1 = LIMIT - CNT_W'(1);

  state_t           state;
  logic [1:0]       stat_q;
  logic [3:0]       icode_q;
  logic [TO_W-1:0]  mem_cnt;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] cycles_q;

  logic stage_busy;
  logic mem_op;
  logic limit_reached;
  logic limit_next;
  logic halt_retire;
  logic ret_inc;
  logic cnt_clr;

  assign stage_busy    = (state == S_FETCH)  || (state == S_DECODE) || (state == S_EXECUTE) ||
                         (state == S_MEMORY) || (state == S_WB)     || (state == S_PCUPD);
  assign mem_op        = is_mem_op(icode_q);
  assign limit_reached = LIMIT_ON && (retired_q >= LIMIT);
  // Retire lands one cycle after PCUPD, so look one instruction ahead.
  assign limit_next    = LIMIT_ON && (retired_q >= LIMIT_M1);
  assign halt_retire   = (state == S_FETCH) && !bus.imem_error && bus.instr_valid &&
                         (bus.icode == IHALT);
  assign ret_inc       = (state == S_PCUPD) || halt_retire;
  assign cnt_clr       = bus.clear &&
                         ((state == S_IDLE) || (state == S_HALTED) || (state == S_FAULT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= IHALT;
      mem_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.clear) begin
            stat_q <= STAT_AOK;
          end else if ((bus.run && !limit_reached) || bus.step) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          icode_q <= bus.icode;
          if (bus.imem_error) begin
            state  <= S_FAULT;
            stat_q <= STAT_ADR;
          end else if (!bus.instr_valid) begin
            state  <= S_FAULT;
            stat_q <= STAT_INS;
          end else if (bus.icode == IHALT) begin
            state  <= S_HALTED;
            stat_q <= STAT_HLT;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          mem_cnt <= '0;
          state   <= S_MEMORY;
        end
        S_MEMORY: begin
          if (!mem_op) begin
            state <= S_WB;
          end else if (bus.mem_ready) begin
            if (bus.dmem_error) begin
              state  <= S_FAULT;
              stat_q <= STAT_ADR;
            end else begin
              state <= S_WB;
            end
          end else if (mem_cnt == TO_LAST) begin
            state  <= S_FAULT;
            stat_q <= STAT_ADR;
          end else begin
            mem_cnt <= mem_cnt + TO_W'(1);
          end
        end
        S_WB: state <= S_PCUPD;
        S_PCUPD: begin
          if (bus.run && !limit_next) begin
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALTED, S_FAULT: begin
          if (bus.clear) begin
            state  <= S_IDLE;
            stat_q <= STAT_AOK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (ret_inc),
    .q     (retired_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stage_busy),
    .q     (cycles_q)
  );

  assign bus.en_fetch   = (state == S_FETCH);
  assign bus.en_decode  = (state == S_DECODE);
  assign bus.en_execute = (state == S_EXECUTE);
  assign bus.en_memory  = (state == S_MEMORY);
  assign bus.en_wb      = (state == S_WB);
  assign bus.en_pc      = (state == S_PCUPD);
  assign bus.mem_req    = (state == S_MEMORY) && mem_op;
  assign bus.busy       = stage_busy;
  assign bus.stat       = stat_q;
  assign bus.retired    = retired_q;
  assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: table of single-instruction outcomes plus
// hand sequences for memory wait, halt, timeout, instruction limit and async reset.
module tb_seq_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  seq_controller_if #(.CNT_W(32)) bus ();
  seq_controller_if #(.CNT_W(32)) lim ();

  seq_controller #(.CNT_W(32), .MEM_TIMEOUT(15), .MAX_INSTR(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  seq_controller #(.CNT_W(32), .MEM_TIMEOUT(15), .MAX_INSTR(3)) u_lim (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lim.slave)
  );

  typedef struct {
    logic [3:0] icode;
    logic       iv;
    logic       ie;
    logic       de;
    logic [1:0] stat;
    int         ret;
    int         cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    bus.run   = 1'b0;
    bus.step  = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  function automatic logic [5:0] en_vec();
    return {bus.en_fetch, bus.en_decode, bus.en_execute, bus.en_memory, bus.en_wb, bus.en_pc};
  endfunction

  initial begin
    int n;
    int mq;
    int bad;
    int f;
    logic [5:0] oh;

    vecs[0] = '{icode: 4'h6, iv: 1'b1, ie: 1'b0, de: 1'b0, stat: 2'b00, ret: 1, cyc: 6};
    vecs[1] = '{icode: 4'h5, iv: 1'b1, ie: 1'b0, de: 1'b0, stat: 2'b00, ret: 1, cyc: 6};
    vecs[2] = '{icode: 4'h0, iv: 1'b1, ie: 1'b0, de: 1'b0, stat: 2'b01, ret: 1, cyc: 1};
    vecs[3] = '{icode: 4'h6, iv: 1'b0, ie: 1'b0, de: 1'b0, stat: 2'b11, ret: 0, cyc: 1};
    vecs[4] = '{icode: 4'h6, iv: 1'b0, ie: 1'b1, de: 1'b0, stat: 2'b10, ret: 0, cyc: 1};
    vecs[5] = '{icode: 4'h8, iv: 1'b1, ie: 1'b0, de: 1'b1, stat: 2'b10, ret: 0, cyc: 4};
    vecs[6] = '{icode: 4'h2, iv: 1'b1, ie: 1'b0, de: 1'b0, stat: 2'b00, ret: 1, cyc: 6};
    vecs[7] = '{icode: 4'hB, iv: 1'b1, ie: 1'b0, de: 1'b0, stat: 2'b00, ret: 1, cyc: 6};

    bus.run = 1'b0; bus.step = 1'b0; bus.clear = 1'b0; bus.icode = 4'h6;
    bus.instr_valid = 1'b1; bus.imem_error = 1'b0; bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
    lim.run = 1'b0; lim.step = 1'b0; lim.clear = 1'b0; lim.icode = 4'h6;
    lim.instr_valid = 1'b1; lim.imem_error = 1'b0; lim.mem_ready = 1'b1; lim.dmem_error = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    chk("reset_en", 32'(en_vec()), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_mem_req", 32'(bus.mem_req), 32'h0);
    chk("reset_stat", 32'(bus.stat), 32'h0);
    chk("reset_retired", bus.retired, 32'h0);
    chk("reset_cycles", bus.cycles, 32'h0);

    // Single step of a non-memory instruction walks every strobe once.
    bus.icode = 4'h6;
    bus.step  = 1'b1;
    tick();
    bus.step = 1'b0;
    oh = 6'b100000;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("step_onehot_%0d", k), 32'(en_vec()), 32'(oh >> k));
      tick();
    end
    chk("step_busy", 32'(bus.busy), 32'h0);
    chk("step_retired", bus.retired, 32'd1);
    chk("step_cycles", bus.cycles, 32'd6);
    chk("step_stat", 32'(bus.stat), 32'h0);

    // Table of single-step outcomes; data memory answers immediately.
    for (int i = 0; i < 8; i++) begin
      clear_pulse();
      bus.icode       = vecs[i].icode;
      bus.instr_valid = vecs[i].iv;
      bus.imem_error  = vecs[i].ie;
      bus.dmem_error  = vecs[i].de;
      bus.mem_ready   = 1'b1;
      bus.step        = 1'b1;
      tick();
      bus.step = 1'b0;
      n = 0;
      bad = 0;
      while (bus.busy && n < 100) begin
        if (!$onehot(en_vec())) bad++;
        n++;
        tick();
      end
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_onehot", i), 32'(bad), 32'h0);
      chk($sformatf("vec%0d_stat", i), 32'(bus.stat), 32'(vecs[i].stat));
      chk($sformatf("vec%0d_retired", i), bus.retired, 32'(vecs[i].ret));
      chk($sformatf("vec%0d_cycles", i), bus.cycles, 32'(vecs[i].cyc));
      bus.instr_valid = 1'b1;
      bus.imem_error  = 1'b0;
      bus.dmem_error  = 1'b0;
    end

    // Run mode, memory instruction with mem_ready on the fourth mem_req cycle.
    clear_pulse();
    bus.mem_ready = 1'b0;
    bus.icode     = 4'h5;
    bus.run       = 1'b1;
    tick();
    chk("memw_first_fetch", 32'(bus.en_fetch), 32'h1);
    n = 0;
    mq = 0;
    do begin
      if (bus.mem_req) begin
        mq++;
        bus.mem_ready = (mq == 4);
      end else begin
        bus.mem_ready = 1'b0;
      end
      tick();
      n++;
    end while (!bus.en_fetch && n < 50);
    chk("memw_instr_len", 32'(n), 32'd9);
    chk("memw_req_cycles", 32'(mq), 32'd4);
    chk("memw_next_fetch", 32'(bus.en_fetch), 32'h1);
    chk("memw_retired", bus.retired, 32'd1);
    bus.mem_ready  = 1'b1;
    bus.dmem_error = 1'b1;
    bus.run        = 1'b0;
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      tick();
    end
    chk("dmem_err_len", 32'(n), 32'd4);
    chk("dmem_err_stat", 32'(bus.stat), 32'h2);
    chk("dmem_err_retired", bus.retired, 32'd1);
    bus.dmem_error = 1'b0;
    bus.run  = 1'b1;
    bus.step = 1'b1;
    f = 0;
    repeat (5) begin
      tick();
      if (bus.en_fetch) f++;
    end
    chk("fault_sticky", 32'(f), 32'h0);
    bus.step = 1'b0;

    // Halt under run, sticky for 20 cycles, then clear.
    clear_pulse();
    bus.icode = 4'h0;
    bus.run   = 1'b1;
    tick();
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      tick();
    end
    chk("halt_stat", 32'(bus.stat), 32'h1);
    chk("halt_retired", bus.retired, 32'd1);
    f = 0;
    repeat (20) begin
      if (bus.en_fetch) f++;
      tick();
    end
    chk("halt_no_fetch", 32'(f), 32'h0);
    bus.run   = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_stat", 32'(bus.stat), 32'h0);
    chk("clear_retired", bus.retired, 32'h0);
    chk("clear_cycles", bus.cycles, 32'h0);
    chk("clear_busy", 32'(bus.busy), 32'h0);

    // mem_ready never arrives.
    clear_pulse();
    bus.icode     = 4'h4;
    bus.mem_ready = 1'b0;
    bus.step      = 1'b1;
    tick();
    bus.step = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      n++;
      tick();
    end
    mq = 0;
    while (bus.mem_req && mq < 40) begin
      mq++;
      tick();
    end
    chk("timeout_req_cycles", 32'(mq), 32'd15);
    chk("timeout_stat", 32'(bus.stat), 32'h2);
    chk("timeout_busy", 32'(bus.busy), 32'h0);
    chk("timeout_retired", bus.retired, 32'h0);

    // Instruction limit of three in run mode.
    lim.run = 1'b1;
    tick();
    n = 0;
    while (lim.busy && n < 100) begin
      n++;
      tick();
    end
    chk("limit_len", 32'(n), 32'd18);
    chk("limit_retired", lim.retired, 32'd3);
    chk("limit_cycles", lim.cycles, 32'd18);
    chk("limit_stat", 32'(lim.stat), 32'h0);
    f = 0;
    repeat (10) begin
      if (lim.en_fetch) f++;
      tick();
    end
    chk("limit_run_ignored", 32'(f), 32'h0);

    // Asynchronous reset in the middle of EXECUTE.
    lim.run  = 1'b0;
    lim.step = 1'b1;
    tick();
    lim.step = 1'b0;
    tick();
    tick();
    chk("pre_rst_execute", 32'(lim.en_execute), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'({lim.en_fetch, lim.en_decode, lim.en_execute,
                              lim.en_memory, lim.en_wb, lim.en_pc}), 32'h0);
    chk("async_rst_busy", 32'(lim.busy), 32'h0);
    chk("async_rst_mem_req", 32'(lim.mem_req), 32'h0);
    chk("async_rst_retired", lim.retired, 32'h0);
    chk("async_rst_cycles", lim.cycles, 32'h0);
    chk("async_rst_stat", 32'(lim.stat), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
